// File: rtl/rtype_exec_ctrl.sv
// rtype_exec_ctrl: multi-cycle MIPS R-type execute controller in front of reg_file.
// One instruction per handshake: IDLE -> RD -> EX -> WB -> IDLE.
// Compile-time option: define RTYPE_OVF_TRAP_EN to make ADD/SUB trap on signed overflow.
//
// Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
// instr_ready is high only in IDLE; while busy, instr_valid is ignored and the upstream
// holds its instruction until it sees instr_ready again.
module rtype_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_r1,
    output logic [4:0]  rf_r2,
    output logic [4:0]  rf_rd,
    output logic        rf_wr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_out1,
    input  logic [31:0] rf_out2,
    output logic [31:0] result,
    output logic        done,
    output logic        illegal,
    output logic        ovf,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      state_q;
    logic        instr_ready_q;
    logic [4:0]  rf_r1_q;
    logic [4:0]  rf_r2_q;
    logic [4:0]  rf_rd_q;
    logic        rf_wr_q;
    logic [31:0] rf_wdata_q;
    logic [31:0] result_q;
    logic        done_q;
    logic        illegal_q;
    logic        ovf_q;

    // Latched instruction fields; rs/rt go straight into the read-address registers.
    logic [5:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  shamt_q;
    logic [5:0]  funct_q;

    logic [31:0] sum_d;
    logic [31:0] diff_d;
    logic [31:0] alu_d;
    logic        legal_d;
    logic        trap_d;
`ifdef RTYPE_OVF_TRAP_EN
    logic        signed_ovf_d;
`endif

    // ALU, legality decode and overflow trap detection for the latched instruction.
    always_comb begin
        sum_d   = rf_out1 + rf_out2;
        diff_d  = rf_out1 - rf_out2;
        alu_d   = '0;
        legal_d = 1'b1;
        trap_d  = 1'b0;
`ifdef RTYPE_OVF_TRAP_EN
        signed_ovf_d = 1'b0;
`endif
        case (funct_q)
            6'h20, 6'h21: alu_d = sum_d;
            6'h22, 6'h23: alu_d = diff_d;
            6'h24:        alu_d = rf_out1 & rf_out2;
            6'h25:        alu_d = rf_out1 | rf_out2;
            6'h26:        alu_d = rf_out1 ^ rf_out2;
            6'h27:        alu_d = ~(rf_out1 | rf_out2);
            6'h2A:        alu_d = {31'b0, ($signed(rf_out1) < $signed(rf_out2))};
            6'h2B:        alu_d = {31'b0, (rf_out1 < rf_out2)};
            6'h00:        alu_d = rf_out2 << shamt_q;
            6'h02:        alu_d = rf_out2 >> shamt_q;
            6'h03:        alu_d = $unsigned($signed(rf_out2) >>> shamt_q);
            default:      legal_d = 1'b0;
        endcase
        if (op_q != 6'd0) begin
            legal_d = 1'b0;
        end
`ifdef RTYPE_OVF_TRAP_EN
        // Only the trapping forms: operands of equal (ADD) or opposite (SUB) sign
        // whose result flips sign relative to A.
        if (funct_q == 6'h20) begin
            signed_ovf_d = (rf_out1[31] == rf_out2[31]) && (sum_d[31] != rf_out1[31]);
        end else if (funct_q == 6'h22) begin
            signed_ovf_d = (rf_out1[31] != rf_out2[31]) && (diff_d[31] != rf_out1[31]);
        end
        trap_d = legal_d && signed_ovf_d;
`endif
        if (!legal_d) begin
            alu_d = '0;
        end
    end

    // Controller FSM; every output is a register updated on the state transition into
    // the cycle where it must be valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_ready_q <= 1'b1;
            rf_r1_q       <= '0;
            rf_r2_q       <= '0;
            rf_rd_q       <= '0;
            rf_wr_q       <= 1'b0;
            rf_wdata_q    <= '0;
            result_q      <= '0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            ovf_q         <= 1'b0;
            op_q          <= '0;
            rd_q          <= '0;
            shamt_q       <= '0;
            funct_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q          <= instr[31:26];
                        rd_q          <= instr[15:11];
                        shamt_q       <= instr[10:6];
                        funct_q       <= instr[5:0];
                        rf_r1_q       <= instr[25:21];
                        rf_r2_q       <= instr[20:16];
                        instr_ready_q <= 1'b0;
                        state_q       <= S_RD;
                    end
                end
                S_RD: begin
                    // reg_file samples rf_r1/rf_r2 at the end of this cycle.
                    state_q <= S_EX;
                end
                S_EX: begin
                    result_q   <= alu_d;
                    rf_wdata_q <= alu_d;
                    rf_rd_q    <= rd_q;
                    // reg_file has no hardwired $0, so writes to rd=0 are dropped here.
                    rf_wr_q    <= legal_d && !trap_d && (rd_q != 5'd0);
                    done_q     <= 1'b1;
                    illegal_q  <= !legal_d;
                    ovf_q      <= trap_d;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    rf_wr_q       <= 1'b0;
                    done_q        <= 1'b0;
                    illegal_q     <= 1'b0;
                    ovf_q         <= 1'b0;
                    instr_ready_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign rf_r1       = rf_r1_q;
    assign rf_r2       = rf_r2_q;
    assign rf_rd       = rf_rd_q;
    assign rf_wr       = rf_wr_q;
    assign rf_wdata    = rf_wdata_q;
    assign result      = result_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Self-checking bench for rtype_exec_ctrl: behavioural reg_file, directed scenarios,
// randomized instruction stream scored against a reference model.
module tb_rtype_exec_ctrl;

`ifdef RTYPE_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [4:0]  rf_r1, rf_r2, rf_rd;
    logic        rf_wr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_out1, rf_out2;
    logic [31:0] result;
    logic        done, illegal, ovf;
    logic [1:0]  dbg_state;

    rtype_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_r1       (rf_r1),
        .rf_r2       (rf_r2),
        .rf_rd       (rf_rd),
        .rf_wr       (rf_wr),
        .rf_wdata    (rf_wdata),
        .rf_out1     (rf_out1),
        .rf_out2     (rf_out2),
        .result      (result),
        .done        (done),
        .illegal     (illegal),
        .ovf         (ovf),
        .dbg_state_o (dbg_state)
    );

    // Behavioural reg_file: registered reads, write port, plus a bench preload port.
    logic [31:0] mem [32] = '{default: 32'h0};
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        rf_out1 <= mem[rf_r1];
        rf_out2 <= mem[rf_r2];
        if (rf_wr) begin
            mem[rf_rd] <= rf_wdata;
            wr_count   <= wr_count + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    // Scoreboard state
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_regs [32];
    logic [31:0] last_result;
    logic        last_wr, last_ill, last_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Reference model: what the instruction should retire with, from the ISA rules.
    function automatic void ref_model(input logic [31:0] w, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic ill, output logic ov, output logic wr);
        longint sa, sb, wide;
        int     sh;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        sh   = int'(w[10:6]);
        res  = 32'h0;
        ill  = 1'b0;
        ov   = 1'b0;
        wide = 0;
        if (w[31:26] != 6'd0) begin
            ill = 1'b1;
        end else begin
            case (w[5:0])
                6'h20, 6'h21: begin
                    res  = a + b;
                    wide = sa + sb;
                    if (w[5:0] == 6'h20 && (wide > 64'sd2147483647 || wide < -64'sd2147483648))
                        ov = TRAP_EN;
                end
                6'h22, 6'h23: begin
                    res  = a - b;
                    wide = sa - sb;
                    if (w[5:0] == 6'h22 && (wide > 64'sd2147483647 || wide < -64'sd2147483648))
                        ov = TRAP_EN;
                end
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
                6'h00: res = b << sh;
                6'h02: res = b >> sh;
                6'h03: res = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                default: ill = 1'b1;
            endcase
        end
        if (ill) res = 32'h0;
        wr = !ill && !ov && (w[15:11] != 5'd0);
    endfunction

    // Driver: preload one register while the controller is idle.
    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
        ref_regs[addr] = data;
    endtask

    // Driver + checker for one instruction. Entered and left on a negedge with the
    // controller idle. hold=1 keeps instr_valid high (back-to-back issue).
    task automatic run_instr(input logic [31:0] w, input bit hold);
        logic [31:0] er, popped;
        logic        ei, eo, ew;
        int          n;
        bit          seen;
        instr       = w;
        instr_valid = 1'b1;
        check_val("ready_idle", 32'(instr_ready), 32'd1);
        ref_model(w, ref_regs[w[25:21]], ref_regs[w[20:16]], er, ei, eo, ew);
        exp_q.push_back(er);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            instr_valid = 1'b0;
            instr       = $urandom;
        end
        check_val("rd_r1", 32'(rf_r1), 32'(w[25:21]));
        check_val("rd_r2", 32'(rf_r2), 32'(w[20:16]));
        check_val("rd_no_wr", 32'(rf_wr), 32'd0);
        check_val("rd_busy", 32'(instr_ready), 32'd0);
        n    = 1;
        seen = 1'b0;
        if (done) seen = 1'b1;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        popped = exp_q.pop_front();
        check_val("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_val("done_latency", n, 32'd3);
            check_val("result", result, popped);
            check_val("wdata", rf_wdata, popped);
            check_val("wr_en", 32'(rf_wr), 32'(ew));
            if (ew) check_val("wr_addr", 32'(rf_rd), 32'(w[15:11]));
            check_val("illegal", 32'(illegal), 32'(ei));
            check_val("ovf", 32'(ovf), 32'(eo));
            last_result = result;
            last_wr     = rf_wr;
            last_ill    = illegal;
            last_ovf    = ovf;
            if (ew) ref_regs[w[15:11]] = er;
        end
        @(negedge clk);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("wr_pulse", 32'(rf_wr), 32'd0);
        check_val("ready_back", 32'(instr_ready), 32'd1);
    endtask

    logic [5:0] functs [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    initial begin
        logic [31:0] w, old3;
        int          wr_before;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_ready", 32'(instr_ready), 32'd1);
        check_val("rst_r1r2rd", {17'h0, rf_r1, rf_r2, rf_rd}, 32'd0);
        check_val("rst_wr", 32'(rf_wr), 32'd0);
        check_val("rst_wdata", rf_wdata, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_flags", {29'h0, done, illegal, ovf}, 32'd0);
        @(negedge clk);

        // ADD $3,$1,$2 with 5 + 7
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        w = enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        check_val("add_encoding", w, 32'h0022_1820);
        run_instr(w, 1'b0);
        check_val("add_result", last_result, 32'd12);
        check_val("add_wr", 32'(last_wr), 32'd1);
        check_val("add_mem3", mem[3], 32'd12);

        // Signed overflow on ADD
        preload(5'd1, 32'h7FFF_FFFF);
        preload(5'd2, 32'd1);
        old3 = mem[3];
        run_instr(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1'b0);
        check_val("ovf_result", last_result, 32'h8000_0000);
        check_val("ovf_flag", 32'(last_ovf), 32'(TRAP_EN));
        check_val("ovf_wr", 32'(last_wr), 32'(!TRAP_EN));
        check_val("ovf_mem3", mem[3], TRAP_EN ? old3 : 32'h8000_0000);
        // ADDU never traps
        run_instr(enc(6'd0, 5'd1, 5'd2, 5'd7, 5'd0, 6'h21), 1'b0);
        check_val("addu_noovf", 32'(last_ovf), 32'd0);

        // Shifts
        preload(5'd2, 32'h8000_0000);
        run_instr(enc(6'd0, 5'd0, 5'd2, 5'd4, 5'd4, 6'h03), 1'b0);
        check_val("sra_result", last_result, 32'hF800_0000);
        run_instr(enc(6'd0, 5'd9, 5'd2, 5'd4, 5'd4, 6'h02), 1'b0);
        check_val("srl_result", last_result, 32'h0800_0000);

        // Illegal: non-zero opcode, then unsupported funct
        run_instr(enc(6'h08, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20), 1'b0);
        check_val("ill_op_flag", 32'(last_ill), 32'd1);
        check_val("ill_op_result", last_result, 32'd0);
        run_instr(enc(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h3F), 1'b0);
        check_val("ill_fn_flag", 32'(last_ill), 32'd1);
        check_val("ill_fn_wr", 32'(last_wr), 32'd0);

        // Write to $0 suppressed
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_instr(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 1'b0);
        check_val("r0_result", last_result, 32'd12);
        check_val("r0_wr", 32'(last_wr), 32'd0);
        check_val("r0_mem", mem[0], 32'd0);

        // Back-to-back dependent ops with instr_valid held high
        run_instr(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1'b1);
        run_instr(enc(6'd0, 5'd3, 5'd1, 5'd4, 5'd0, 6'h22), 1'b0);
        check_val("dep_result", last_result, 32'd7);

        // Reset in EX: instruction dropped, no write
        wr_before   = wr_count;
        instr       = enc(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_ex_ready", 32'(instr_ready), 32'd1);
        repeat (4) begin
            check_val("rst_ex_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        check_val("rst_ex_nowr", wr_count, wr_before);
        check_val("rst_ex_mem5", mem[5], ref_regs[5]);

        // Reset in WB: the write sampled on that edge still commits
        instr       = enc(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h23);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_wb_done", 32'(done), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_wb_done_off", 32'(done), 32'd0);
        check_val("rst_wb_mem6", mem[6], 32'hFFFF_FFFE);
        ref_regs[6] = 32'hFFFF_FFFE;
        @(negedge clk);

        // Randomized stream
        for (int i = 1; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       preload(5'(i), 32'h7FFF_FFFF);
                1:       preload(5'(i), 32'h8000_0000);
                default: preload(5'(i), $urandom);
            endcase
        end
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op, fn;
            op = 6'd0;
            fn = functs[$urandom_range(0, 12)];
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) op = 6'($urandom_range(1, 63));
                else fn = 6'h3F;
            end
            run_instr(enc(op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), fn),
                      1'($urandom_range(0, 1)));
        end
        instr_valid = 1'b0;
        @(negedge clk);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        // Final register file contents against the model
        for (int i = 0; i < 32; i++) begin
            check_val($sformatf("regfile_%0d", i), mem[i], ref_regs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
